bcd_decade_counter: RTL and testbench

- Single-digit BCD up-counter: 0,1,…,9,0,…, advancing once every DIV clock cycles through an internal prescaler.
- Used as a slow decade/seconds-style digit source.
- Terminal-count output allows cascading multiple digits.
- Leaf block, single clock domain.

---
 rtl/bcd_counter_pkg.sv | 43 ++++
 rtl/bcd_prescaler.sv | 37 +++
 rtl/bcd_decade_counter.sv | 47 ++++
 tb/tb_bcd_decade_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared constants, digit type and 7-segment table for the BCD decade counter.
// The SEG_* table is only consumed when BCD_DECADE_COUNTER_SEG_EN is defined.
package bcd_counter_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Active-high segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [6:0] seg_decode(input bcd_t digit);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_prescaler.sv
// Divide-by-DIV tick generator: tick is high during the last cycle of each DIV-cycle period.
module bcd_prescaler #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV <= 1) begin : g_div1
            // Prescaler degenerates to a constant zero; every edge is a tick.
            assign tick = 1'b1;
        end else begin : g_divn
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] r_cnt;
            logic          w_last;

            assign w_last = (r_cnt == LAST);
            assign tick   = w_last;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bcd_decade_counter.sv
// Single-digit BCD up-counter advancing once every DIV clocks, with cascade terminal count.
// Define BCD_DECADE_COUNTER_SEG_EN to add the seg[6:0] 7-segment decode output.
module bcd_decade_counter
    import bcd_counter_pkg::*;
#(
    parameter int unsigned DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] bcd,
    output logic       tc
`ifdef BCD_DECADE_COUNTER_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    bcd_t r_bcd;
    logic w_tick;

    bcd_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Codes above 9 are unreachable but still recover to 0 on the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd <= '0;
        end else if (w_tick) begin
            r_bcd <= (r_bcd >= BCD_MAX) ? bcd_t'(0) : r_bcd + bcd_t'(1);
        end
    end

    assign bcd = r_bcd;
    assign tc  = (r_bcd == BCD_MAX) && w_tick;

`ifdef BCD_DECADE_COUNTER_SEG_EN
    assign seg = seg_decode(r_bcd);
`else
    // No segment output in this build.
`endif

endmodule

// File: tb/tb_bcd_decade_counter.sv
// Bench for bcd_decade_counter: DIV=8 and DIV=1 instances against an edge-count model.
`timescale 1ns/1ps
module tb_bcd_decade_counter;

    logic       clk;
    logic       reset;
    logic [3:0] bcd8;
    logic       tc8;
    logic [3:0] bcd1;
    logic       tc1;
`ifdef BCD_DECADE_COUNTER_SEG_EN
    logic [6:0] seg8;
    logic [6:0] seg1;
`endif

    int total;
    int bad;
    int n_edges;   // rising edges seen with reset high since last reset

    bcd_decade_counter #(
        .DIV (8)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .bcd   (bcd8),
        .tc    (tc8)
`ifdef BCD_DECADE_COUNTER_SEG_EN
        ,
        .seg   (seg8)
`endif
    );

    bcd_decade_counter #(
        .DIV (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bcd   (bcd1),
        .tc    (tc1)
`ifdef BCD_DECADE_COUNTER_SEG_EN
        ,
        .seg   (seg1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic int seg_ref(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 0;
        endcase
    endfunction

    // Model: digit = (edges / DIV) mod 10, tick on the last edge of each DIV window.
    always @(posedge clk) begin
        int e8;
        int e1;
        if (!reset) n_edges = 0;
        else        n_edges = n_edges + 1;
        #2;
        if (!reset) begin
            check("rst_bcd8", bcd8, 0);
            check("rst_tc8", tc8, 0);
            check("rst_bcd1", bcd1, 0);
            check("rst_tc1", tc1, 0);
        end else begin
            e8 = (n_edges / 8) % 10;
            e1 = n_edges % 10;
            check("bcd8", bcd8, e8);
            check("tc8", tc8, ((e8 == 9) && (n_edges % 8 == 7)) ? 1 : 0);
            check("bcd1", bcd1, e1);
            check("tc1", tc1, (e1 == 9) ? 1 : 0);
`ifdef BCD_DECADE_COUNTER_SEG_EN
            check("seg8", seg8, seg_ref(e8));
            check("seg1", seg1, seg_ref(e1));
`endif
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        n_edges = 0;
        reset   = 1'b0;
        #1;
        check("hold_bcd8", bcd8, 0);
        check("hold_tc8", tc8, 0);
        #9 reset = 1'b1;                                     // t=10
        #30 check("t40_bcd8", bcd8, 0);                      // t=40
        #40 check("t80_bcd8", bcd8, 0);                      // t=80
        #40 check("t120_bcd8", bcd8, 1);                     // t=120
        #80 check("t200_bcd8", bcd8, 2);                     // t=200
        #520 check("t720_bcd8", bcd8, 8);                    // t=720
        #10;                                                 // t=730
        check("t730_bcd8", bcd8, 9);
        check("t730_tc8", tc8, 0);
        #60;                                                 // t=790
        check("t790_tc8", tc8, 0);
        #10;                                                 // t=800
        check("t800_bcd8", bcd8, 9);
        check("t800_tc8", tc8, 1);
        #10;                                                 // t=810
        check("t810_bcd8", bcd8, 0);
        check("t810_tc8", tc8, 0);
        #400 check("t1210_bcd8", bcd8, 5);                   // t=1210
        #30 reset = 1'b0;                                    // t=1240, mid-cycle
        #1;
        check("async_bcd8", bcd8, 0);
        check("async_tc8", tc8, 0);
        check("async_bcd1", bcd1, 0);
        #19 reset = 1'b1;                                    // t=1260
        #70 check("t1330_bcd8", bcd8, 0);                    // t=1330
        #10 check("t1340_bcd8", bcd8, 1);                    // t=1340
        #660;                                                // t=2000
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
